// File: rtl/ap_ctrl_sequencer_pkg.sv
// Shared types and default widths for the ap_ctrl sequencer and its latency statistics block.
package ap_ctrl_sequencer_pkg;

  localparam int NUM_W_DEF = 16;
  localparam int GAP_W_DEF = 8;
  localparam int LAT_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_GAP       = 3'd3,
    ST_FIN       = 3'd4
  } state_e;

endpackage

// File: rtl/ap_ctrl_sequencer_lat_stats.sv
// Saturating per-transaction latency counter with last/min/max capture registers.
module ap_lat_stats
  import ap_ctrl_sequencer_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             capture,
  output logic [LAT_W-1:0] last_lat,
  output logic [LAT_W-1:0] min_lat,
  output logic [LAT_W-1:0] max_lat
);

  localparam logic [LAT_W-1:0] LAT_MAX = '1;

  logic [LAT_W-1:0] lat_q, lat_d, lat_cur;
  logic [LAT_W-1:0] last_q, last_d;
  logic [LAT_W-1:0] min_q, min_d;
  logic [LAT_W-1:0] max_q, max_d;

  // lat_cur is the latency of the current cycle, so a capture in the load cycle reports 1.
  always_comb begin
    lat_cur = (lat_q == LAT_MAX) ? lat_q : lat_q + LAT_W'(1);
    if (load) begin
      lat_cur = LAT_W'(1);
    end
    lat_d  = lat_cur;
    last_d = last_q;
    min_d  = min_q;
    max_d  = max_q;
    if (clear) begin
      last_d = '0;
      min_d  = LAT_MAX;
      max_d  = '0;
    end else if (capture) begin
      last_d = lat_cur;
      if (lat_cur < min_q) min_d = lat_cur;
      if (lat_cur > max_q) max_d = lat_cur;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat_q  <= '0;
      last_q <= '0;
      min_q  <= LAT_MAX;
      max_q  <= '0;
    end else begin
      lat_q  <= lat_d;
      last_q <= last_d;
      min_q  <= min_d;
      max_q  <= max_d;
    end
  end

  assign last_lat = last_q;
  assign min_lat  = min_q;
  assign max_lat  = max_q;

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// Drives an HLS-style ap_ctrl_chain block through a configured number of transactions,
// inserting idle gaps and collecting latency statistics.
module ap_ctrl_sequencer
  import ap_ctrl_sequencer_pkg::*;
#(
  parameter int NUM_W = NUM_W_DEF,
  parameter int GAP_W = GAP_W_DEF,
  parameter int LAT_W = LAT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_go,
  input  logic [NUM_W-1:0] cfg_num_txn,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic             hold_continue,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic             busy,
  output logic             finish,
  output logic [NUM_W-1:0] txn_count,
  output logic [LAT_W-1:0] last_lat,
  output logic [LAT_W-1:0] min_lat,
  output logic [LAT_W-1:0] max_lat,
  output logic             err_protocol,
  output state_e           dbg_state
);

  localparam logic [NUM_W-1:0] TXN_MAX = '1;

  // Handshakes: ap_start is held until the cycle ap_ready is high (input accepted on that
  // edge); ap_done is held by the DUT and a transaction completes on the edge where
  // ap_done and ap_continue are both high, which may coincide with the ap_ready edge.

  state_e           state_q, state_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [NUM_W-1:0] txn_q, txn_d, txn_inc;
  logic             err_q, err_d;
  logic             first_q, first_d;
  logic             in_xfer;
  logic             cont;
  logic             done_acc;
  logic             go_acc;
  logic             violation;
  logic             stat_clear;

  assign in_xfer  = (state_q == ST_START) || (state_q == ST_WAIT_DONE);
  assign cont     = in_xfer && !hold_continue;
  assign done_acc = ap_done && cont;
  assign txn_inc  = (txn_q == TXN_MAX) ? txn_q : txn_q + NUM_W'(1);

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
    txn_d      = txn_q;
    go_acc     = 1'b0;
    violation  = 1'b0;
    stat_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        violation = ap_done || ap_ready;
        if (cfg_go) begin
          go_acc = 1'b1;
          num_d  = cfg_num_txn;
          gap_d  = cfg_gap;
          txn_d  = '0;
          if (cfg_num_txn == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d    = ST_START;
            stat_clear = 1'b1;
          end
        end
      end
      ST_START, ST_WAIT_DONE: begin
        violation = (state_q == ST_WAIT_DONE) && ap_ready;
        if (done_acc) begin
          txn_d = txn_inc;
          if (txn_inc >= num_q) begin
            state_d = ST_FIN;
          end else if (gap_q == '0) begin
            state_d = ST_START;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_W'(1);
          end
        end else if ((state_q == ST_START) && ap_ready) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_GAP: begin
        violation = ap_done || ap_ready;
        if (gap_cnt_q == gap_q) begin
          state_d = ST_START;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      ST_FIN: begin
        violation = ap_done || ap_ready;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    err_d = err_q;
    if (go_acc)    err_d = 1'b0;
    if (violation) err_d = 1'b1;

    // A completion that re-enters START begins a fresh transaction.
    first_d = (state_d == ST_START) && ((state_q != ST_START) || done_acc);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      num_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      txn_q     <= '0;
      err_q     <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      txn_q     <= txn_d;
      err_q     <= err_d;
      first_q   <= first_d;
    end
  end

  ap_lat_stats #(
    .LAT_W (LAT_W)
  ) u_lat_stats (
    .clock    (clock),
    .reset    (reset),
    .clear    (stat_clear),
    .load     (first_q),
    .capture  (done_acc),
    .last_lat (last_lat),
    .min_lat  (min_lat),
    .max_lat  (max_lat)
  );

  assign ap_start     = (state_q == ST_START);
  assign ap_continue  = cont;
  assign busy         = in_xfer || (state_q == ST_GAP);
  assign finish       = (state_q == ST_FIN);
  assign txn_count    = txn_q;
  assign err_protocol = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Directed bench for ap_ctrl_sequencer: a responder models the controlled block, and
// expected latencies are queued per run and checked as each transaction completes.
module tb_ap_ctrl_sequencer;
  import ap_ctrl_sequencer_pkg::*;

  localparam int NUM_W = 16;
  localparam int GAP_W = 8;
  localparam int LAT_W = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             cfg_go;
  logic [NUM_W-1:0] cfg_num_txn;
  logic [GAP_W-1:0] cfg_gap;
  logic             hold_continue;
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_continue;
  logic             busy;
  logic             finish;
  logic [NUM_W-1:0] txn_count;
  logic [LAT_W-1:0] last_lat;
  logic [LAT_W-1:0] min_lat;
  logic [LAT_W-1:0] max_lat;
  logic             err_protocol;
  state_e           dbg_state;

  always #5 clock = ~clock;

  ap_ctrl_sequencer #(
    .NUM_W (NUM_W),
    .GAP_W (GAP_W),
    .LAT_W (LAT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cfg_go        (cfg_go),
    .cfg_num_txn   (cfg_num_txn),
    .cfg_gap       (cfg_gap),
    .hold_continue (hold_continue),
    .ap_start      (ap_start),
    .ap_ready      (ap_ready),
    .ap_done       (ap_done),
    .ap_continue   (ap_continue),
    .busy          (busy),
    .finish        (finish),
    .txn_count     (txn_count),
    .last_lat      (last_lat),
    .min_lat       (min_lat),
    .max_lat       (max_lat),
    .err_protocol  (err_protocol),
    .dbg_state     (dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [LAT_W-1:0] exp_q[$];

  // Responder model state
  bit active;
  int cyc;
  int txn_idx;
  int r_arr[4];
  int d_arr[4];
  int h_from;
  int h_len;
  bit chk_pending;
  int rdy_cnt;
  int fin_cnt;
  int gap_cyc;
  int start_cyc;
  bit saw_wait;
  int n_ticks = 0;
  int first_fin_tick;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    active         = 1'b0;
    cyc            = 0;
    txn_idx        = 0;
    rdy_cnt        = 0;
    fin_cnt        = 0;
    gap_cyc        = 0;
    start_cyc      = 0;
    saw_wait       = 1'b0;
    chk_pending    = 1'b0;
    h_from         = 0;
    h_len          = 0;
    first_fin_tick = -1;
    ap_ready       = 1'b0;
    ap_done        = 1'b0;
    hold_continue  = 1'b0;
    r_arr          = '{0, 0, 0, 0};
    d_arr          = '{0, 0, 0, 0};
  endtask

  task automatic tick();
    logic [LAT_W-1:0] e;
    @(negedge clock);
    n_ticks++;
    cfg_go = 1'b0;
    if (chk_pending) begin
      chk_pending = 1'b0;
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("last_lat", last_lat, e);
      end
    end
    if (!active && ap_start) begin
      active = 1'b1;
      cyc    = 0;
    end else if (active) begin
      cyc++;
    end
    ap_ready      = active && ap_start && (cyc >= r_arr[txn_idx]);
    ap_done       = active && (cyc >= d_arr[txn_idx]);
    hold_continue = active && (cyc >= h_from) && (cyc < h_from + h_len);
    #1;
    if (busy && !ap_start && !active) gap_cyc++;
    if (finish) begin
      if (fin_cnt == 0) first_fin_tick = n_ticks;
      fin_cnt++;
    end
    if (ap_start) start_cyc++;
    if (dbg_state == ST_WAIT_DONE) saw_wait = 1'b1;
    if (ap_ready && ap_start) rdy_cnt++;
    if (hold_continue) check("hold_blocks_continue", ap_continue, 0);
    if (ap_done && ap_continue) begin
      chk_pending = 1'b1;
      active      = 1'b0;
      if (txn_idx < 3) txn_idx++;
    end
  endtask

  task automatic run(input int num, input int gap, input bit poke_go);
    int budget;
    cfg_num_txn = NUM_W'(num);
    cfg_gap     = GAP_W'(gap);
    cfg_go      = 1'b1;
    tick();
    cfg_num_txn = NUM_W'(1);
    cfg_gap     = GAP_W'(0);
    budget      = 0;
    while (fin_cnt == 0 && budget < 300) begin
      if (poke_go && budget == 3) cfg_go = 1'b1;
      tick();
      budget++;
    end
    check("run_within_budget", budget < 300, 1);
    repeat (3) tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ap_start"}, ap_start, 0);
    check({tag, "_ap_continue"}, ap_continue, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_finish"}, finish, 0);
    check({tag, "_txn_count"}, txn_count, 0);
    check({tag, "_last_lat"}, last_lat, 0);
    check({tag, "_max_lat"}, max_lat, 0);
    check({tag, "_min_lat"}, min_lat, 64'h0000_0000_FFFF_FFFF);
    check({tag, "_err"}, err_protocol, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    int t0;
    int budget;
    reset       = 1'b0;
    cfg_go      = 1'b0;
    cfg_num_txn = '0;
    cfg_gap     = '0;
    clear_model();

    repeat (2) @(negedge clock);
    #1;
    check_reset_values("reset");
    reset = 1'b1;

    // Three back-to-back transactions, latency 5 each, with a stray cfg_go mid-run
    clear_model();
    r_arr = '{1, 1, 1, 0};
    d_arr = '{4, 4, 4, 0};
    exp_q.push_back(LAT_W'(5));
    exp_q.push_back(LAT_W'(5));
    exp_q.push_back(LAT_W'(5));
    run(3, 0, 1'b1);
    check("t1_txn_count", txn_count, 3);
    check("t1_ready_handshakes", rdy_cnt, 3);
    check("t1_finish_pulses", fin_cnt, 1);
    check("t1_last", last_lat, 5);
    check("t1_min", min_lat, 5);
    check("t1_max", max_lat, 5);
    check("t1_gap_cycles", gap_cyc, 0);
    check("t1_err", err_protocol, 0);
    check("t1_sb_drained", exp_q.size(), 0);

    // Two transactions with a 3-cycle gap, latencies 2 then 7
    clear_model();
    r_arr = '{0, 0, 0, 0};
    d_arr = '{1, 6, 0, 0};
    exp_q.push_back(LAT_W'(2));
    exp_q.push_back(LAT_W'(7));
    run(2, 3, 1'b0);
    check("t2_txn_count", txn_count, 2);
    check("t2_gap_cycles", gap_cyc, 3);
    check("t2_min", min_lat, 2);
    check("t2_max", max_lat, 7);
    check("t2_last", last_lat, 7);
    check("t2_finish_pulses", fin_cnt, 1);
    check("t2_err", err_protocol, 0);

    // Ready and done together in the first START cycle
    clear_model();
    exp_q.push_back(LAT_W'(1));
    run(1, 0, 1'b0);
    check("t3_last", last_lat, 1);
    check("t3_no_wait_done", saw_wait, 0);
    check("t3_txn_count", txn_count, 1);
    check("t3_ready_handshakes", rdy_cnt, 1);
    check("t3_err", err_protocol, 0);

    // Done held across a 5-cycle continue hold
    clear_model();
    d_arr  = '{1, 0, 0, 0};
    h_from = 1;
    h_len  = 5;
    exp_q.push_back(LAT_W'(7));
    run(1, 0, 1'b0);
    check("t4_last", last_lat, 7);
    check("t4_txn_count", txn_count, 1);
    check("t4_err", err_protocol, 0);

    // Asynchronous reset in WAIT_DONE, then a stray ap_done while idle
    clear_model();
    d_arr       = '{100, 0, 0, 0};
    cfg_num_txn = NUM_W'(1);
    cfg_gap     = GAP_W'(0);
    cfg_go      = 1'b1;
    budget      = 0;
    while (dbg_state != ST_WAIT_DONE && budget < 20) begin
      tick();
      budget++;
    end
    check("t5_reached_wait_done", dbg_state, ST_WAIT_DONE);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("t5_async_reset");
    clear_model();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    ap_done = 1'b1;
    @(negedge clock);
    ap_done = 1'b0;
    #1;
    check("t5_err_set", err_protocol, 1);
    check("t5_busy", busy, 0);

    // Zero-transaction run
    clear_model();
    t0 = n_ticks;
    run(0, 0, 1'b0);
    check("t6_finish_timing", first_fin_tick - t0, 1);
    check("t6_finish_pulses", fin_cnt, 1);
    check("t6_no_ap_start", start_cyc, 0);
    check("t6_txn_count", txn_count, 0);
    check("t6_err_cleared", err_protocol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
